// File: rtl/arm_regfile_mp.sv
// arm_regfile_mp
//   Multi-read-port ARM register file. It sits between ID, which reads and
//   issues, and WB, which writes back. It has a writeback port, a link port
//   for BL that writes LINK_REG, and optional same-cycle write-to-read bypass.
//   A per-register busy scoreboard marks registers that have a producer in
//   flight, and the hazard unit consumes the result.
// Ports
//   clk, rst              clock; synchronous active-high reset
//   wb_en/wb_dest/wb_data writeback port (1-cycle write latency)
//   lnk_en/lnk_data       link write to LINK_REG (wins over wb on same reg)
//   issue_en/issue_dest   marks issue_dest busy
//   rd_addr  [NUM_RD*ADDR_W]  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  [NUM_RD*DATA_W]  packed combinational read data
//   rd_busy  [NUM_RD]         read address has a pending writer
//   hazard                    OR of rd_busy
module arm_regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int LINK_REG = 14,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_dest,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     lnk_en,
  input  logic [DATA_W-1:0]        lnk_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_dest,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     hazard
);

  if (NUM_REGS > (1 << ADDR_W)) begin : g_bad_num_regs
    $error("arm_regfile_mp: NUM_REGS exceeds 2**ADDR_W");
  end
  if (LINK_REG >= NUM_REGS) begin : g_bad_link_reg
    $error("arm_regfile_mp: LINK_REG must be below NUM_REGS");
  end
  if (NUM_RD < 1) begin : g_bad_num_rd
    $error("arm_regfile_mp: NUM_RD must be at least 1");
  end

  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  localparam logic              BYP    = (BYPASS != 0);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic wb_ok;
  logic issue_ok;

  // Out-of-range addresses are silently dropped.
  assign wb_ok    = wb_en && (int'(wb_dest) < NUM_REGS);
  assign issue_ok = issue_en && (int'(issue_dest) < NUM_REGS);

  // The link write comes after wb so it wins on LINK_REG.
  // The issue set comes after both clears so a new producer keeps the
  // register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_ok) begin
      regs_d[wb_dest] = wb_data;
      busy_d[wb_dest] = 1'b0;
    end
    if (lnk_en) begin
      regs_d[LINK_REG] = lnk_data;
      busy_d[LINK_REG] = 1'b0;
    end
    if (issue_ok) begin
      busy_d[issue_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DATA_W'(i);
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              in_rng;
    logic              lnk_hit;
    logic              wb_hit;
    logic [DATA_W-1:0] arr_val;

    assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign in_rng  = (int'(addr) < NUM_REGS);
    assign arr_val = in_rng ? regs_q[addr] : '0;
    assign lnk_hit = BYP && !rst && lnk_en && (addr == LINK_A);
    assign wb_hit  = BYP && !rst && wb_ok && (addr == wb_dest);

    assign rd_data[k*DATA_W +: DATA_W] = lnk_hit ? lnk_data :
                                         wb_hit  ? wb_data  : arr_val;
    // A forwarded value is already valid, so it does not count as busy.
    assign rd_busy[k] = in_rng && busy_q[addr] && !(lnk_hit || wb_hit);
  end

  assign hazard = |rd_busy;

endmodule

// File: tb/tb_arm_regfile_mp.sv
module tb_arm_regfile_mp;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int NRD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, wb_en, lnk_en, issue_en;
  logic [AW-1:0]   wb_dest, issue_dest;
  logic [DW-1:0]   wb_data, lnk_data;
  logic [NRD*AW-1:0] rd_addr;

  logic [NRD*DW-1:0] rd_data_a, rd_data_b;
  logic [NRD-1:0]    rd_busy_a, rd_busy_b;
  logic              hazard_a, hazard_b;

  // Instance A: default configuration with bypass.
  arm_regfile_mp dut_a (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .lnk_en(lnk_en), .lnk_data(lnk_data), .issue_en(issue_en),
    .issue_dest(issue_dest), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .hazard(hazard_a)
  );

  // Instance B: no bypass, 12 registers (addresses 12..15 out of range), link r10.
  arm_regfile_mp #(.NUM_REGS(12), .LINK_REG(10), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .lnk_en(lnk_en), .lnk_data(lnk_data), .issue_en(issue_en),
    .issue_dest(issue_dest), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .hazard(hazard_b)
  );

  typedef struct {
    logic [NRD*DW-1:0] da;
    logic [NRD-1:0]    ba;
    logic              ha;
    logic [NRD*DW-1:0] db;
    logic [NRD-1:0]    bb;
    logic              hb;
    int                tag;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: register contents and busy flags per instance.
  logic [DW-1:0] mregs [2][16];
  bit            mbusy [2][16];
  int cfg_n   [2] = '{16, 12};
  int cfg_l   [2] = '{14, 10};
  bit cfg_byp [2] = '{1'b1, 1'b0};
  bit model_valid = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int tag_cnt     = 0;
  bit stim_done   = 1'b0;

  function automatic void model_read(input int m, output logic [NRD*DW-1:0] d,
                                     output logic [NRD-1:0] b);
    d = '0;
    b = '0;
    for (int k = 0; k < NRD; k++) begin
      int a;
      logic [DW-1:0] v;
      bit fwd;
      a   = int'(rd_addr[k*AW +: AW]);
      fwd = 1'b0;
      if (a >= cfg_n[m]) begin
        v = '0;
      end else if (cfg_byp[m] && !rst && lnk_en && a == cfg_l[m]) begin
        v = lnk_data; fwd = 1'b1;
      end else if (cfg_byp[m] && !rst && wb_en && int'(wb_dest) < cfg_n[m] &&
                   a == int'(wb_dest)) begin
        v = wb_data; fwd = 1'b1;
      end else begin
        v = mregs[m][a];
      end
      d[k*DW +: DW] = v;
      b[k] = (a < cfg_n[m]) && mbusy[m][a] && !fwd;
    end
  endfunction

  function automatic void model_update(input int m);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mregs[m][i] = DW'(i);
        mbusy[m][i] = 1'b0;
      end
    end else begin
      if (wb_en && int'(wb_dest) < cfg_n[m]) begin
        mregs[m][wb_dest] = wb_data;
        mbusy[m][wb_dest] = 1'b0;
      end
      if (lnk_en) begin
        mregs[m][cfg_l[m]] = lnk_data;
        mbusy[m][cfg_l[m]] = 1'b0;
      end
      if (issue_en && int'(issue_dest) < cfg_n[m]) mbusy[m][issue_dest] = 1'b1;
    end
  endfunction

  task automatic apply(input logic r, input logic we, input logic [AW-1:0] wd,
                       input logic [DW-1:0] wdat, input logic le,
                       input logic [DW-1:0] ld, input logic ie,
                       input logic [AW-1:0] id, input logic [AW-1:0] ra0,
                       input logic [AW-1:0] ra1);
    exp_t e;
    rst = r; wb_en = we; wb_dest = wd; wb_data = wdat;
    lnk_en = le; lnk_data = ld; issue_en = ie; issue_dest = id;
    rd_addr = {ra1, ra0};
    if (model_valid) begin
      model_read(0, e.da, e.ba);
      model_read(1, e.db, e.bb);
      e.ha = |e.ba;
      e.hb = |e.bb;
      e.tag = tag_cnt;
      tag_cnt++;
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_update(0);
    model_update(1);
    model_valid = 1'b1;
    #1;
  endtask

  // Monitor: outputs are combinational, so one vector is presented per cycle
  // and sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if ({rd_data_a, rd_busy_a, hazard_a} !== {e.da, e.ba, e.ha}) begin
          miscompares++;
          $display("FAIL byp_inst vec%0d: got data=%h busy=%b hz=%b want data=%h busy=%b hz=%b",
                   e.tag, rd_data_a, rd_busy_a, hazard_a, e.da, e.ba, e.ha);
        end
        if ({rd_data_b, rd_busy_b, hazard_b} !== {e.db, e.bb, e.hb}) begin
          miscompares++;
          $display("FAIL nobyp_inst vec%0d: got data=%h busy=%b hz=%b want data=%h busy=%b hz=%b",
                   e.tag, rd_data_b, rd_busy_b, hazard_b, e.db, e.bb, e.hb);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; wb_en = 1'b0; lnk_en = 1'b0; issue_en = 1'b0;
    wb_dest = '0; issue_dest = '0; wb_data = '0; lnk_data = '0; rd_addr = '0;

    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset values: r3 / r7
    apply(0, 0, 0, 0, 0, 0, 0, 0, 4'd3, 4'd7);
    // wb r5 with same-cycle read, then the following cycle
    apply(0, 1, 4'd5, 32'hDEADBEEF, 0, 0, 0, 0, 4'd5, 4'd5);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 4'd5, 4'd5);
    // wb and link collide on r14 (r10 for instance B)
    apply(0, 1, 4'd14, 32'h1111, 1, 32'h2222, 0, 0, 4'd14, 4'd10);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 4'd14, 4'd10);
    apply(0, 1, 4'd10, 32'h3333, 1, 32'h4444, 0, 0, 4'd10, 4'd14);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 4'd10, 4'd14);
    // issue r2, hazard, then writeback clears it
    apply(0, 0, 0, 0, 0, 0, 1, 4'd2, 4'd0, 4'd1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 4'd2, 4'd1);
    apply(0, 1, 4'd2, 32'd9, 0, 0, 0, 0, 4'd2, 4'd2);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 4'd2, 4'd0);
    // issue and writeback to r4 on the same edge: busy stays set
    apply(0, 1, 4'd4, 32'h44, 0, 0, 1, 4'd4, 4'd0, 4'd0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 4'd4, 4'd4);
    // out-of-range write/issue/read (instance B)
    apply(0, 1, 4'd13, 32'h55, 0, 0, 1, 4'd12, 4'd13, 4'd12);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 4'd13, 4'd12);
    // reset on the same edge as wb r6 and issue r6
    apply(0, 0, 0, 0, 0, 0, 1, 4'd9, 4'd9, 4'd6);
    apply(1, 1, 4'd6, 32'hAA, 1, 32'h77, 1, 4'd6, 4'd6, 4'd9);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 4'd6, 4'd9);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 4'd14, 4'd4);

    for (int n = 0; n < 600; n++) begin
      logic r, we, le, ie;
      logic [AW-1:0] wd, id, ra0, ra1;
      r   = ($urandom_range(0, 59) == 0);
      we  = $urandom_range(0, 1);
      le  = ($urandom_range(0, 3) == 0);
      ie  = ($urandom_range(0, 2) != 0);
      wd  = AW'($urandom_range(0, 15));
      id  = AW'($urandom_range(0, 15));
      ra0 = ($urandom_range(0, 2) == 0) ? wd : AW'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 3) == 0) ? id : AW'($urandom_range(0, 15));
      apply(r, we, wd, $urandom, le, $urandom, ie, id, ra0, ra1);
    end

    wb_en = 1'b0; lnk_en = 1'b0; issue_en = 1'b0; rst = 1'b0;
    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
